// File: rtl/display_pkg.sv
// display_pkg: shared constants for the measurement display slice.
//   - Active-low seven-segment patterns, bit0=a .. bit6=g.
//   - Conversion FSM state type.
//   - Measurement unit codes shared with the measurement block.
//   - BCD nibble adjust helper used by the double-dabble engine.
package display_pkg;

  localparam int unsigned NUM_W  = 14;
  localparam int unsigned DIGITS = 5;
  localparam int unsigned ITER   = NUM_W;
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned CNT_W  = $clog2(ITER);

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_T     = 7'b0000111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  localparam logic [2:0] MEAS_NONE = 3'd0;
  localparam logic [2:0] MEAS_X    = 3'd1;
  localparam logic [2:0] MEAS_Y    = 3'd2;

  // Add 3 to every nibble >= 5 so the following left shift carries correctly.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/measure_display_seven_seg_decoder.sv
// seven_seg_decoder: one BCD digit to active-low seven-segment pattern.
// Ports:
//   digit_i  4-bit digit value (10..15 shown as a dash)
//   blank_i  forces all segments off
//   seg_o    active-low segments, bit0=a .. bit6=g
module seven_seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/measure_display.sv
// measure_display: converts the 14-bit measurement value to five decimal
// digits (sequential double-dabble, one bit per clock) and drives HEX0..HEX4,
// with a unit letter on HEX5. A conversion starts only when num differs from
// the last committed value; the displays decode committed digits only.
// Ports:
//   clock        system clock
//   resetN       asynchronous reset, active-low
//   num          unsigned value to display
//   measurement  unit select for HEX5 (0 none, 1 cursor x, 2 cursor y)
//   hex0..hex4   digit segments, active-low, hex0 least significant
//   hex5         unit letter segments, active-low
//   busy         conversion in progress
//   updated      one-cycle pulse after new digits are committed
// Build option: LEADING_ZERO_BLANK_EN blanks zero digits above the most
// significant non-zero digit (hex0 always shown).
module measure_display
  import display_pkg::*;
(
  input  logic             clock,
  input  logic             resetN,
  input  logic [NUM_W-1:0] num,
  input  logic [2:0]       measurement,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [6:0]       hex3,
  output logic [6:0]       hex4,
  output logic [6:0]       hex5,
  output logic             busy,
  output logic             updated
);

  state_t             state_q, state_d;
  logic [NUM_W-1:0]   num_latched_q, num_latched_d;
  logic [NUM_W-1:0]   last_num_q, last_num_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [NUM_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic               updated_q, updated_d;
  logic [BCD_W+NUM_W-1:0] shifted;
  logic [DIGITS-1:0]  blank;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q       <= ST_IDLE;
      num_latched_q <= '0;
      last_num_q    <= '0;
      bcd_q         <= '0;
      shreg_q       <= '0;
      cnt_q         <= '0;
      digits_q      <= '0;
      updated_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_latched_q <= num_latched_d;
      last_num_q    <= last_num_d;
      bcd_q         <= bcd_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      digits_q      <= digits_d;
      updated_q     <= updated_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    num_latched_d = num_latched_q;
    last_num_d    = last_num_q;
    bcd_d         = bcd_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    digits_d      = digits_q;
    updated_d     = 1'b0;
    shifted       = {bcd_adjust(bcd_q), shreg_q} << 1;
    case (state_q)
      ST_IDLE: begin
        if (num != last_num_q) begin
          num_latched_d = num;
          state_d       = ST_LOAD;
        end
      end
      ST_LOAD: begin
        bcd_d   = '0;
        shreg_d = num_latched_q;
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        bcd_d   = shifted[BCD_W+NUM_W-1:NUM_W];
        shreg_d = shifted[NUM_W-1:0];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER - 1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        digits_d   = bcd_q;
        last_num_d = num_latched_q;
        updated_d  = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign updated = updated_q;

`ifdef LEADING_ZERO_BLANK_EN
  // A digit blanks only if it and every digit above it are zero.
  always_comb begin
    blank    = '0;
    blank[4] = (digits_q[19:16] == 4'd0);
    blank[3] = blank[4] && (digits_q[15:12] == 4'd0);
    blank[2] = blank[3] && (digits_q[11:8] == 4'd0);
    blank[1] = blank[2] && (digits_q[7:4] == 4'd0);
  end
`else
  assign blank = '0;
`endif

  seven_seg_decoder u_dec0 (.digit_i(digits_q[3:0]),   .blank_i(blank[0]), .seg_o(hex0));
  seven_seg_decoder u_dec1 (.digit_i(digits_q[7:4]),   .blank_i(blank[1]), .seg_o(hex1));
  seven_seg_decoder u_dec2 (.digit_i(digits_q[11:8]),  .blank_i(blank[2]), .seg_o(hex2));
  seven_seg_decoder u_dec3 (.digit_i(digits_q[15:12]), .blank_i(blank[3]), .seg_o(hex3));
  seven_seg_decoder u_dec4 (.digit_i(digits_q[19:16]), .blank_i(blank[4]), .seg_o(hex4));

  always_comb begin
    case (measurement)
      MEAS_NONE: hex5 = SEG_BLANK;
      MEAS_X:    hex5 = SEG_T;
      MEAS_Y:    hex5 = SEG_U;
      default:   hex5 = SEG_DASH;
    endcase
  end

endmodule

// File: tb/tb_measure_display.sv
// Self-checking bench for measure_display: table of values with hand-computed
// segment patterns, plus hand-written sequences for restart, reset abort,
// toggle-back and the HEX5 unit letter.
module tb_measure_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010, S8 = 7'b0000000, S9 = 7'b0010000;
  localparam logic [6:0] B  = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetN;
  logic [13:0] num;
  logic [2:0]  measurement;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        busy, updated;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  typedef struct {
    logic [13:0] num;
    logic [34:0] pad;   // {hex4,hex3,hex2,hex1,hex0}, leading zeros shown
    logic [34:0] blk;   // same, leading zeros blanked
  } vec_t;

  vec_t vecs[6];

  measure_display dut (
    .clock(clock), .resetN(resetN), .num(num), .measurement(measurement),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4),
    .hex5(hex5), .busy(busy), .updated(updated)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (updated === 1'b1) pulses++;

  function automatic logic [34:0] pick(input logic [34:0] pad, input logic [34:0] blk);
    return BLK ? blk : pad;
  endfunction

  task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits at negedges until updated is seen; expiry counts as a failure.
  task automatic wait_updated(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (updated === 1'b1) seen = 1'b1;
    end
    chk({name, "_timeout"}, 35'(seen), 35'd1);
  endtask

  logic [34:0] prev;
  int          p0;

  initial begin
    vecs[0] = '{num: 14'd6,     pad: {S0,S0,S0,S0,S6}, blk: {B,B,B,B,S6}};
    vecs[1] = '{num: 14'd16383, pad: {S1,S6,S3,S8,S3}, blk: {S1,S6,S3,S8,S3}};
    vecs[2] = '{num: 14'd1024,  pad: {S0,S1,S0,S2,S4}, blk: {B,S1,S0,S2,S4}};
    vecs[3] = '{num: 14'd9,     pad: {S0,S0,S0,S0,S9}, blk: {B,B,B,B,S9}};
    vecs[4] = '{num: 14'd10005, pad: {S1,S0,S0,S0,S5}, blk: {S1,S0,S0,S0,S5}};
    vecs[5] = '{num: 14'd0,     pad: {S0,S0,S0,S0,S0}, blk: {B,B,B,B,S0}};

    // Reset state
    resetN = 1'b0; num = '0; measurement = 3'd0;
    repeat (3) @(negedge clock);
    chk("rst_hex", {hex4,hex3,hex2,hex1,hex0}, pick({S0,S0,S0,S0,S0}, {B,B,B,B,S0}));
    chk("rst_busy", 35'(busy), 35'd0);
    chk("rst_upd", 35'(updated), 35'd0);
    resetN = 1'b1;
    p0 = pulses;
    repeat (40) @(negedge clock);
    chk("idle_no_pulse", 35'(pulses - p0), 35'd0);
    chk("idle_busy", 35'(busy), 35'd0);
    prev = pick({S0,S0,S0,S0,S0}, {B,B,B,B,S0});

    // Table: exact 17-edge latency, stable display until commit, single pulse
    for (int unsigned v = 0; v < 6; v++) begin
      num = vecs[v].num;
      @(posedge clock); @(negedge clock);
      chk($sformatf("v%0d_busy_edge1", v), 35'(busy), 35'd1);
      repeat (15) @(posedge clock);
      @(negedge clock);
      chk($sformatf("v%0d_hold_edge16", v), {hex4,hex3,hex2,hex1,hex0}, prev);
      chk($sformatf("v%0d_upd_edge16", v), 35'(updated), 35'd0);
      @(posedge clock); @(negedge clock);
      chk($sformatf("v%0d_hex", v), {hex4,hex3,hex2,hex1,hex0}, pick(vecs[v].pad, vecs[v].blk));
      chk($sformatf("v%0d_upd", v), 35'(updated), 35'd1);
      @(posedge clock); @(negedge clock);
      chk($sformatf("v%0d_upd_off", v), 35'(updated), 35'd0);
      chk($sformatf("v%0d_idle", v), 35'(busy), 35'd0);
      prev = pick(vecs[v].pad, vecs[v].blk);
    end

    // num changes mid-conversion: 100 commits first, then 250
    p0 = pulses;
    num = 14'd100;
    repeat (4) @(negedge clock);
    num = 14'd250;
    wait_updated("chg100", 30);
    chk("chg_first", {hex4,hex3,hex2,hex1,hex0}, pick({S0,S0,S1,S0,S0}, {B,B,S1,S0,S0}));
    wait_updated("chg250", 30);
    chk("chg_second", {hex4,hex3,hex2,hex1,hex0}, pick({S0,S0,S2,S5,S0}, {B,B,S2,S5,S0}));
    repeat (40) @(negedge clock);
    chk("chg_pulses", 35'(pulses - p0), 35'd2);

    // Reset mid-conversion of 9999, then restart after release
    p0 = pulses;
    num = 14'd9999;
    repeat (7) @(negedge clock);
    resetN = 1'b0;
    #1;
    chk("abort_hex", {hex4,hex3,hex2,hex1,hex0}, pick({S0,S0,S0,S0,S0}, {B,B,B,B,S0}));
    chk("abort_busy", 35'(busy), 35'd0);
    repeat (3) @(negedge clock);
    chk("abort_no_pulse", 35'(pulses - p0), 35'd0);
    resetN = 1'b1;
    wait_updated("restart", 30);
    chk("restart_hex", {hex4,hex3,hex2,hex1,hex0}, pick({S0,S9,S9,S9,S9}, {B,S9,S9,S9,S9}));
    repeat (5) @(negedge clock);
    chk("restart_pulses", 35'(pulses - p0), 35'd1);

    // Glitch back to last value between edges: no conversion
    num = 14'd1234;
    #2;
    num = 14'd9999;
    @(negedge clock);
    chk("toggle_busy", 35'(busy), 35'd0);

    // HEX5 unit letter
    measurement = 3'd0; #1; chk("hex5_none", 35'(hex5), 35'(B));
    measurement = 3'd1; #1; chk("hex5_x",    35'(hex5), 35'(7'b0000111));
    measurement = 3'd2; #1; chk("hex5_y",    35'(hex5), 35'(7'b1000001));
    measurement = 3'd5; #1; chk("hex5_other", 35'(hex5), 35'(7'b0111111));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
